// File: rtl/param_seq_core.sv
// Parametrised 4-bit-opcode sequencer core: fetches from a combinational ROM, executes one instruction per cycle.
// Latency: single cycle per instruction (PC and register write on the same edge). Backpressure: run=0 freezes PC/regs/sp/state.
// Optional CALL/RET stack built only when PSC_STACK_EN is defined; otherwise CALL/RET are NOPs and fault is tied low.
module param_seq_core #(
    parameter int DATA_W      = 4,
    parameter int F_W         = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [2*F_W-1:0]      progaddr,
    input  logic [4+2*F_W-1:0]    progdata,
    input  logic [2*DATA_W-1:0]   datain,
    output logic [2*DATA_W-1:0]   dataout,
    output logic                  halted,
    output logic                  fault
);
    localparam int PADDR_W = 2 * F_W;
    localparam int INST_W  = 4 + 2 * F_W;
    localparam int NREG    = 2 ** F_W;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_GOTO, OP_CALL, OP_STOP, OP_EJ0, OP_EJ1, OP_CJ0, OP_CJ1,
        OP_MOVE, OP_GIVE, OP_SUB, OP_ADD, OP_EQ, OP_CMP, OP_RET, OP_NOP2
    } op_t;

    state_t                state_q, state_d;
    logic [PADDR_W-1:0]    pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0]     regs_q [NREG];
    logic [DATA_W-1:0]     regs_d [NREG];

    op_t                   op;
    logic [F_W-1:0]        fa, fb;
    logic [PADDR_W-1:0]    target;
    logic [DATA_W-1:0]     ra, rb, imm;
    logic [DATA_W:0]       sum;
    logic                  exec;

`ifdef PSC_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic [SP_W-1:0]       sp_q, sp_d;
    logic [PADDR_W-1:0]    stack_q [STACK_DEPTH];
    logic [PADDR_W-1:0]    ret_addr;
    logic                  push;
`endif

    assign op     = op_t'(progdata[INST_W-1 -: 4]);
    assign fa     = progdata[2*F_W-1:F_W];
    assign fb     = progdata[F_W-1:0];
    assign target = progdata[PADDR_W-1:0];
    assign ra     = regs_q[fa];
    assign rb     = regs_q[fb];
    assign imm    = DATA_W'(fb);
    assign sum    = {1'b0, ra} + {1'b0, rb};
    assign pc_inc = pc_q + PADDR_W'(1);
    assign exec   = run && (state_q == ST_RUN);

`ifdef PSC_STACK_EN
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) ret_addr = stack_q[i];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        regs_d  = regs_q;
`ifdef PSC_STACK_EN
        sp_d    = sp_q;
        push    = 1'b0;
`endif
        if (exec) begin
            pc_d = pc_inc;
            case (op)
                OP_GOTO: pc_d = target;
                OP_STOP: begin
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end
                OP_EJ0:  if (!regs_q[2][0]) pc_d = target;
                OP_EJ1:  if (regs_q[2][0])  pc_d = target;
                OP_CJ0:  if (!regs_q[3][0]) pc_d = target;
                OP_CJ1:  if (regs_q[3][0])  pc_d = target;
                OP_MOVE: regs_d[fa] = rb;
                OP_GIVE: regs_d[fa] = imm;
                OP_SUB:  regs_d[fa] = (ra > rb) ? (ra - rb) : (rb - ra);
                OP_ADD: begin
                    regs_d[fa] = sum[DATA_W-1:0];
                    // carry written last so it wins when a selects R1
                    regs_d[1]  = DATA_W'(sum[DATA_W]);
                end
                OP_EQ:   regs_d[2] = DATA_W'(ra == rb);
                OP_CMP:  regs_d[3] = DATA_W'(ra > rb);
`ifdef PSC_STACK_EN
                OP_CALL: begin
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        state_d = ST_FAULT;
                        pc_d    = pc_q;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        state_d = ST_FAULT;
                        pc_d    = pc_q;
                    end else begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = ret_addr;
                    end
                end
`endif
                default: ;
            endcase
        end
        // input port registers track datain regardless of run/state
        regs_d[4] = datain[DATA_W-1:0];
        regs_d[5] = datain[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            regs_q  <= regs_d;
        end
    end

`ifdef PSC_STACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && (sp_q == SP_W'(i))) stack_q[i] <= pc_inc;
            end
        end
    end
    assign fault = (state_q == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    assign progaddr = pc_q;
    assign dataout  = {regs_q[7], regs_q[6]};
    assign halted   = (state_q != ST_RUN);
endmodule

// File: tb/tb_param_seq_core.sv
// Testbench for param_seq_core (DATA_W=4, F_W=4, STACK_DEPTH=2): directed table, corner sequences, random vs model.
module tb_param_seq_core;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  progaddr;
    logic [11:0] progdata;
    logic [7:0]  datain = 8'h00;
    logic [7:0]  dataout;
    logic        halted, fault;

    logic [11:0] rom [256];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign progdata = rom[progaddr];

    param_seq_core #(.DATA_W(4), .F_W(4), .STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .run(run), .progaddr(progaddr), .progdata(progdata),
        .datain(datain), .dataout(dataout), .halted(halted), .fault(fault)
    );

    typedef struct packed {
        logic [7:0][11:0] prog;
        logic [7:0]       din;
        logic [7:0]       cycles;
        logic [7:0]       exp_dout;
        logic [7:0]       exp_pc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] P(input logic [11:0] i0, i1, i2, i3, i4, i5, i6, i7);
        return {i7, i6, i5, i4, i3, i2, i1, i0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        run = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // reference model state
    int m_reg [16];
    int m_pc, m_state;
    int m_stk [$];

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_pc = 0;
        m_state = 0;
        m_stk.delete();
    endtask

    task automatic m_step(input bit r, input int din);
        int op, a, b, ra, rb, tgt, npc;
        if (m_state == 0 && r) begin
            op = int'(rom[m_pc][11:8]);
            a  = int'(rom[m_pc][7:4]);
            b  = int'(rom[m_pc][3:0]);
            ra = m_reg[a];
            rb = m_reg[b];
            tgt = a * 16 + b;
            npc = (m_pc + 1) % 256;
            case (op)
                1: npc = tgt;
                3: begin m_state = 1; npc = m_pc; end
                4: if (m_reg[2] % 2 == 0) npc = tgt;
                5: if (m_reg[2] % 2 == 1) npc = tgt;
                6: if (m_reg[3] % 2 == 0) npc = tgt;
                7: if (m_reg[3] % 2 == 1) npc = tgt;
                8: m_reg[a] = rb;
                9: m_reg[a] = b;
                10: m_reg[a] = (ra > rb) ? ra - rb : rb - ra;
                11: begin m_reg[a] = (ra + rb) % 16; m_reg[1] = (ra + rb) / 16; end
                12: m_reg[2] = (ra == rb) ? 1 : 0;
                13: m_reg[3] = (ra > rb) ? 1 : 0;
`ifdef PSC_STACK_EN
                2: if (m_stk.size() >= SD) begin m_state = 2; npc = m_pc; end
                   else begin m_stk.push_back((m_pc + 1) % 256); npc = tgt; end
                14: if (m_stk.size() == 0) begin m_state = 2; npc = m_pc; end
                    else npc = m_stk.pop_back();
`endif
                default: ;
            endcase
            m_pc = npc;
        end
        m_reg[4] = din % 16;
        m_reg[5] = din / 16;
    endtask

    initial begin
        vecs[0] = '{P(12'h984, 12'h995, 12'hB89, 12'h868, 12'h871, 0, 0, 0), 8'h00, 8'd5, 8'h09, 8'd5};
        vecs[1] = '{P(12'h989, 12'h999, 12'hB89, 12'hC89, 12'h868, 12'h871, 0, 0), 8'h00, 8'd6, 8'h12, 8'd6};
        vecs[2] = '{P(12'h989, 12'h999, 12'hB89, 12'hC89, 12'h862, 12'hA89, 12'h878, 0), 8'h00, 8'd7, 8'h70, 8'd7};
        vecs[3] = '{P(12'h000, 12'h874, 12'h865, 0, 0, 0, 0, 0), 8'h5A, 8'd3, 8'hA5, 8'd3};
        vecs[4] = '{P(12'h000, 12'h943, 12'h864, 0, 0, 0, 0, 0), 8'h5A, 8'd3, 8'h0A, 8'd3};
        vecs[5] = '{P(12'h987, 12'h993, 12'hD89, 12'h706, 12'h960, 12'h96F, 12'h863, 0), 8'h00, 8'd5, 8'h01, 8'd7};
        vecs[6] = '{P(12'h982, 12'h999, 12'hA89, 12'hC89, 12'h406, 12'h97F, 12'h868, 0), 8'h00, 8'd6, 8'h07, 8'd7};
        vecs[7] = '{P(12'h91F, 12'h993, 12'hB19, 12'h861, 0, 0, 0, 0), 8'h00, 8'd4, 8'h01, 8'd4};

        clear_rom();
        #2;
        chk("reset_pc", 32'(progaddr), 0);
        chk("reset_dout", 32'(dataout), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_fault", 32'(fault), 0);

        for (int v = 0; v < 8; v++) begin
            clear_rom();
            for (int k = 0; k < 8; k++) rom[k] = vecs[v].prog[k];
            datain = vecs[v].din;
            do_reset();
            run_cycles(int'(vecs[v].cycles));
            chk($sformatf("vec%0d_dout", v), 32'(dataout), 32'(vecs[v].exp_dout));
            chk($sformatf("vec%0d_pc", v), 32'(progaddr), 32'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_halted", v), 32'(halted), 0);
        end
        datain = 8'h00;

        // nested CALLs overflowing a 2-deep stack
        clear_rom();
        rom[8'h00] = 12'h210; rom[8'h10] = 12'h220; rom[8'h20] = 12'h230;
        do_reset();
        run_cycles(6);
`ifdef PSC_STACK_EN
        chk("call_ovf_pc", 32'(progaddr), 32'h20);
        chk("call_ovf_fault", 32'(fault), 1);
        chk("call_ovf_halted", 32'(halted), 1);
`else
        chk("nostack_call_pc", 32'(progaddr), 6);
        chk("nostack_call_fault", 32'(fault), 0);
`endif
        rom[8'h20] = 12'hE00;
        do_reset();
        run_cycles(3);
`ifdef PSC_STACK_EN
        chk("ret_pc", 32'(progaddr), 32'h11);
        chk("ret_fault", 32'(fault), 0);
`else
        chk("nostack_ret_pc", 32'(progaddr), 3);
`endif
        clear_rom();
        rom[0] = 12'hE00;
        do_reset();
        run_cycles(2);
`ifdef PSC_STACK_EN
        chk("ret_empty_fault", 32'(fault), 1);
        chk("ret_empty_pc", 32'(progaddr), 0);
`else
        chk("nostack_ret0_fault", 32'(fault), 0);
        chk("nostack_ret0_pc", 32'(progaddr), 2);
`endif

        // STOP then async reset mid-cycle
        clear_rom();
        rom[3] = 12'h300;
        do_reset();
        run_cycles(4);
        chk("stop_halted", 32'(halted), 1);
        run_cycles(10);
        chk("stop_pc_held", 32'(progaddr), 3);
        chk("stop_fault", 32'(fault), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_pc", 32'(progaddr), 0);
        chk("async_reset_halted", 32'(halted), 0);
        @(negedge clk);
        reset = 1'b1;

        // pause mid-program, then resume
        clear_rom();
        for (int k = 0; k < 8; k++) rom[k] = {4'h9, 4'h6, 4'(k + 1)};
        do_reset();
        run_cycles(2);
        run = 1'b0;
        datain = 8'h3C;
        repeat (5) @(negedge clk);
        chk("pause_pc", 32'(progaddr), 2);
        chk("pause_dout", 32'(dataout), 32'h02);
        run_cycles(1);
        chk("resume_pc", 32'(progaddr), 3);
        chk("resume_dout", 32'(dataout), 32'h03);

        // tight GOTO loop
        clear_rom();
        rom[0] = 12'h100;
        do_reset();
        run_cycles(5);
        chk("goto_self_pc", 32'(progaddr), 0);
        chk("goto_self_halted", 32'(halted), 0);

        // random programs against the reference model
        for (int ep = 0; ep < 10; ep++) begin
            for (int i = 0; i < 256; i++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 3 && $urandom_range(0, 7) != 0) op = 9;
                if ((op == 2 || op == 14) && $urandom_range(0, 2) != 0) op = 8;
                rom[i] = {4'(op), 8'($urandom_range(0, 255))};
            end
            do_reset();
            m_reset();
            for (int c = 0; c < 200; c++) begin
                bit r;
                int d;
                r = ($urandom_range(0, 4) != 0);
                d = $urandom_range(0, 255);
                run = r;
                datain = 8'(d);
                @(posedge clk);
                m_step(r, d);
                @(negedge clk);
                chk($sformatf("rand_e%0d_c%0d", ep, c), {13'(0), fault, halted, dataout, progaddr},
                    {13'(0), m_state == 2, m_state != 0, 8'(m_reg[7] * 16 + m_reg[6]), 8'(m_pc)});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
